// File: rtl/csr_except_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csr_except_unit_pkg
// Purpose  : Shared encodings for the machine-mode CSR file and trap unit:
//            CSR addresses, SYSTEM opcode / funct3 values, MRET, cause codes.
// Revision : 1.0 - initial release
// ============================================================================
package csr_except_unit_pkg;

  // SYSTEM opcode and CSR funct3 encodings
  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
  localparam logic [2:0]  F3_PRIV    = 3'b000;
  localparam logic [2:0]  F3_CSRRW   = 3'b001;
  localparam logic [2:0]  F3_CSRRS   = 3'b010;
  localparam logic [2:0]  F3_CSRRC   = 3'b011;
  localparam logic [2:0]  F3_CSRRWI  = 3'b101;
  localparam logic [2:0]  F3_CSRRSI  = 3'b110;
  localparam logic [2:0]  F3_CSRRCI  = 3'b111;

  // Whole-instruction encoding of MRET
  localparam logic [31:0] INSTR_MRET = 32'h3020_0073;

  // Exception cause codes
  localparam logic [3:0]  CAUSE_MISALIGN_FETCH = 4'd0;
  localparam logic [3:0]  CAUSE_ILLEGAL        = 4'd2;
  localparam logic [3:0]  CAUSE_EBREAK         = 4'd3;
  localparam logic [3:0]  CAUSE_MISALIGN_LD    = 4'd4;
  localparam logic [3:0]  CAUSE_MISALIGN_ST    = 4'd6;
  localparam logic [3:0]  CAUSE_ECALL_M        = 4'd11;

  // RV32I base ISA, MXL = 1
  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

endpackage : csr_except_unit_pkg
`default_nettype wire

// File: rtl/csr_except_unit_regfile.sv
`default_nettype none
// ============================================================================
// Module   : csr_regfile
// Purpose  : Machine-mode CSR storage, read mux, software write path and
//            trap/MRET side effects. Counter is 64 bits split over two
//            32-bit halves, so XLEN is expected to be 32.
// Revision : 1.0 - initial release
// ============================================================================
module csr_regfile
  import csr_except_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_rdata,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_val,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_en,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o
);

  logic            mstatus_mie_q,  mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0] mie_q,      mie_d;
  logic [XLEN-1:0] mtvec_q,    mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q,     mepc_d;
  logic [XLEN-1:0] mcause_q,   mcause_d;
  logic [XLEN-1:0] mtval_q,    mtval_d;
  logic [63:0]     cycle_q,    cycle_d;
  logic [XLEN-1:0] mstatus_rd;
  logic            addr_writable;

  // mstatus view: MPP hardwired to machine mode, only MIE/MPIE stored
  assign mstatus_rd = XLEN'({19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0});
  // Top two address bits 11 mark the read-only CSR space
  assign addr_writable = (csr_addr[11:10] != 2'b11);
  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

  // Read mux: unimplemented addresses and the ID/mip registers read zero
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:               csr_rdata = mstatus_rd;
      CSR_MISA:                  csr_rdata = XLEN'(MISA_VALUE);
      CSR_MIE:                   csr_rdata = mie_q;
      CSR_MTVEC:                 csr_rdata = mtvec_q;
      CSR_MSCRATCH:              csr_rdata = mscratch_q;
      CSR_MEPC:                  csr_rdata = mepc_q;
      CSR_MCAUSE:                csr_rdata = mcause_q;
      CSR_MTVAL:                 csr_rdata = mtval_q;
      CSR_MCYCLE,  CSR_CYCLE:    csr_rdata = XLEN'(cycle_q[31:0]);
      CSR_MCYCLEH, CSR_CYCLEH:   csr_rdata = XLEN'(cycle_q[63:32]);
      default:                   csr_rdata = '0;
    endcase
  end

  // Next-state: trap beats MRET beats software write; counter free-runs
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    cycle_d        = cycle_q + 64'd1;
    if (trap_en) begin
      mepc_d         = trap_pc & ~XLEN'(3);
      mcause_d       = trap_cause;
      mtval_d        = trap_tval;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_en) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (wr_en && addr_writable) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie_d  = wr_val[3];
          mstatus_mpie_d = wr_val[7];
        end
        CSR_MIE:      mie_d      = wr_val;
        CSR_MTVEC:    mtvec_d    = wr_val & ~XLEN'(3);
        CSR_MSCRATCH: mscratch_d = wr_val;
        CSR_MEPC:     mepc_d     = wr_val & ~XLEN'(3);
        CSR_MCAUSE:   mcause_d   = wr_val;
        CSR_MTVAL:    mtval_d    = wr_val;
        // A software write replaces the increment for that cycle
        CSR_MCYCLE:   cycle_d    = {cycle_q[63:32], wr_val[31:0]};
        CSR_MCYCLEH:  cycle_d    = {wr_val[31:0], cycle_q[31:0]};
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      cycle_q        <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      cycle_q        <= cycle_d;
    end
  end

endmodule : csr_regfile
`default_nettype wire

// File: rtl/csr_except_unit.sv
`default_nettype none
// ============================================================================
// Module   : csr_except_unit
// Purpose  : Writeback-stage CSR access decode plus exception/MRET control.
//            Produces the old CSR value for rd and the fetch redirect.
// Revision : 1.0 - initial release
// ============================================================================
module csr_except_unit
  import csr_except_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int EXW  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] instr,
  input  logic            exception_valid,
  input  logic [EXW-1:0]  exception,
  input  logic [XLEN-1:0] wr_data,
  output logic            flush,
  output logic [XLEN-1:0] flush_addr,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data
);

  logic [2:0]      funct3;
  logic [4:0]      rs1_field;
  logic [11:0]     csr_addr;
  logic            is_csr;
  logic            wr_req;
  logic            mret_hit;
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic [XLEN-1:0] trap_tval;
  logic [XLEN-1:0] mtvec_w;
  logic [XLEN-1:0] mepc_w;

  assign funct3    = instr[14:12];
  assign rs1_field = instr[19:15];
  assign csr_addr  = instr[31:20];
  assign rd_addr   = instr[11:7];
  assign rd_data   = old_val;

  // Decode the CSR op and form the value it would write
  always_comb begin
    is_csr   = (instr[6:0] == OPC_SYSTEM) && (funct3[1:0] != 2'b00);
    src      = funct3[2] ? XLEN'(rs1_field) : wr_data;
    new_val  = src;
    case (funct3[1:0])
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = src;
    endcase
    // Set/clear forms with a zero rs1/zimm field are pure reads
    wr_req   = is_csr && ((funct3[1:0] == 2'b01) || (rs1_field != 5'd0));
    mret_hit = (instr == XLEN'(INSTR_MRET)) && !exception_valid;
    trap_tval = (exception == EXW'(CAUSE_ILLEGAL)) ? instr : '0;
  end

  // Redirect: trap vector on exception, saved PC on MRET, held off in reset
  always_comb begin
    flush      = 1'b0;
    flush_addr = '0;
    if (!reset) begin
      if (exception_valid) begin
        flush      = 1'b1;
        flush_addr = mtvec_w & ~XLEN'(3);
      end else if (mret_hit) begin
        flush      = 1'b1;
        flush_addr = mepc_w;
      end
    end
  end

  csr_regfile #(
    .XLEN (XLEN)
  ) u_csr_regfile (
    .clk        (clk),
    .reset      (reset),
    .csr_addr   (csr_addr),
    .csr_rdata  (old_val),
    .wr_en      (wr_req && !exception_valid),
    .wr_val     (new_val),
    .trap_en    (exception_valid),
    .trap_pc    (PC),
    .trap_cause (XLEN'(exception)),
    .trap_tval  (trap_tval),
    .mret_en    (mret_hit),
    .mtvec_o    (mtvec_w),
    .mepc_o     (mepc_w)
  );

endmodule : csr_except_unit
`default_nettype wire

// File: tb/tb_csr_except_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_except_unit
// Purpose  : Directed self-checking bench for csr_except_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_except_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] instr;
  logic        exception_valid;
  logic [3:0]  exception;
  logic [31:0] wr_data;
  logic        flush;
  logic [31:0] flush_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_except_unit #(.XLEN(32), .EXW(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .PC              (PC),
    .instr           (instr),
    .exception_valid (exception_valid),
    .exception       (exception),
    .wr_data         (wr_data),
    .flush           (flush),
    .flush_addr      (flush_addr),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data)
  );

  function automatic logic [31:0] csr_i(input logic [11:0] a, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {a, rs1, f3, rd, 7'b1110011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pure read (CSRRS rd=x1, rs1=x0), checked before the edge
  task automatic rd_csr(input logic [11:0] a, input logic [31:0] exp, input string tag);
    instr = csr_i(a, 5'd0, 3'b010, 5'd1);
    exception_valid = 1'b0;
    #1;
    chk(tag, rd_data, exp);
    tick();
  endtask

  task automatic wr_csr(input logic [11:0] a, input logic [4:0] rs1, input logic [2:0] f3,
                        input logic [31:0] wd);
    instr = csr_i(a, rs1, f3, 5'd2);
    wr_data = wd;
    exception_valid = 1'b0;
    #1;
    tick();
  endtask

  initial begin
    reset = 1'b1; PC = '0; instr = '0; exception_valid = 1'b0; exception = '0; wr_data = '0;
    tick();
    // Exception presented while in reset must not redirect or update state
    instr = 32'h0000_0073; exception_valid = 1'b1; exception = 4'd11; PC = 32'h40;
    #1;
    chk("flush_in_reset", {31'd0, flush}, 32'd0);
    tick();
    exception_valid = 1'b0;
    instr = csr_i(12'h300, 5'd0, 3'b010, 5'd1);
    #1;
    chk("mstatus_in_reset", rd_data, 32'h0000_1800);
    tick();
    reset = 1'b0;

    rd_csr(12'h341, 32'h0, "mepc_reset");

    // CSRRW x5, mscratch
    instr = csr_i(12'h340, 5'd6, 3'b001, 5'd5); wr_data = 32'hDEADBEEF;
    #1;
    chk("csrrw_old", rd_data, 32'h0);
    chk("csrrw_rd_addr", {27'd0, rd_addr}, 32'd5);
    chk("csrrw_no_flush", {31'd0, flush}, 32'd0);
    tick();
    rd_csr(12'h340, 32'hDEADBEEF, "mscratch_rw");

    // Trap vector then ecall
    wr_csr(12'h305, 5'd1, 3'b001, 32'h0000_0103);
    rd_csr(12'h305, 32'h0000_0100, "mtvec_low_bits");
    instr = 32'h0000_0073; PC = 32'h80; exception_valid = 1'b1; exception = 4'd11;
    #1;
    chk("ecall_flush", {31'd0, flush}, 32'd1);
    chk("ecall_flush_addr", flush_addr, 32'h100);
    tick();
    rd_csr(12'h341, 32'h80, "ecall_mepc");
    rd_csr(12'h342, 32'd11, "ecall_mcause");
    rd_csr(12'h343, 32'h0, "ecall_mtval");
    rd_csr(12'h300, 32'h0000_1800, "ecall_mstatus");

    // Set MIE with CSRRSI zimm=8, then illegal instruction
    wr_csr(12'h300, 5'd8, 3'b110, 32'h0);
    rd_csr(12'h300, 32'h0000_1808, "mie_set");
    instr = 32'hFFFF_FFFF; PC = 32'h86; exception_valid = 1'b1; exception = 4'd2;
    #1;
    chk("illegal_flush_addr", flush_addr, 32'h100);
    tick();
    rd_csr(12'h343, 32'hFFFF_FFFF, "illegal_mtval");
    rd_csr(12'h300, 32'h0000_1880, "illegal_mstatus");
    rd_csr(12'h341, 32'h84, "illegal_mepc_aligned");
    instr = 32'h3020_0073; exception_valid = 1'b0;
    #1;
    chk("mret_flush", {31'd0, flush}, 32'd1);
    chk("mret_flush_addr", flush_addr, 32'h84);
    tick();
    rd_csr(12'h300, 32'h0000_1888, "mret_mstatus");

    // Set/clear with zero field is read-only; CSRRCI clears bits
    instr = csr_i(12'h340, 5'd0, 3'b011, 5'd3); wr_data = 32'hFFFF_FFFF;
    #1;
    chk("csrrc_x0_old", rd_data, 32'hDEADBEEF);
    tick();
    rd_csr(12'h340, 32'hDEADBEEF, "csrrc_x0_nochange");
    wr_csr(12'h340, 5'd1, 3'b001, 32'h0000_000F);
    wr_csr(12'h340, 5'd3, 3'b111, 32'hFFFF_FFFF);
    rd_csr(12'h340, 32'h0000_000C, "csrrci");
    wr_csr(12'h340, 5'd1, 3'b010, 32'h0000_0030);
    rd_csr(12'h340, 32'h0000_003C, "csrrs");

    // Read-only and unimplemented space
    wr_csr(12'hF14, 5'd1, 3'b001, 32'h55);
    rd_csr(12'hF14, 32'h0, "mhartid_ro");
    wr_csr(12'h301, 5'd1, 3'b001, 32'h0);
    rd_csr(12'h301, 32'h4000_0100, "misa_ro");
    wr_csr(12'h7C0, 5'd1, 3'b001, 32'h1234);
    rd_csr(12'h7C0, 32'h0, "unimpl_zero");
    rd_csr(12'h344, 32'h0, "mip_zero");

    // Counter: write wins over increment, then +1 per cycle
    wr_csr(12'hB00, 5'd1, 3'b001, 32'h100);
    rd_csr(12'hB00, 32'h100, "mcycle_0");
    rd_csr(12'hB00, 32'h101, "mcycle_1");
    rd_csr(12'hC00, 32'h102, "cycle_2");
    // Wrap of the full 64-bit counter
    wr_csr(12'hB00, 5'd1, 3'b001, 32'hFFFF_FFFE);
    wr_csr(12'hB80, 5'd1, 3'b001, 32'hFFFF_FFFF);
    rd_csr(12'hB00, 32'hFFFF_FFFE, "wrap_lo");
    rd_csr(12'hB80, 32'hFFFF_FFFF, "wrap_hi");
    rd_csr(12'hC00, 32'h0, "wrap_lo0");
    rd_csr(12'hC80, 32'h0, "wrap_hi0");

    // CSR write together with an exception is suppressed
    instr = csr_i(12'h340, 5'd1, 3'b001, 5'd4); wr_data = 32'h1234; PC = 32'h200;
    exception_valid = 1'b1; exception = 4'd4;
    #1;
    tick();
    rd_csr(12'h340, 32'h0000_003C, "exc_suppress_write");
    rd_csr(12'h342, 32'd4, "exc_mcause4");
    rd_csr(12'h343, 32'h0, "exc_mtval0");

    // Idle: neither flush nor redirect
    instr = 32'h0000_0013; exception_valid = 1'b0;
    #1;
    chk("idle_flush", {31'd0, flush}, 32'd0);
    chk("idle_flush_addr", flush_addr, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_csr_except_unit
`default_nettype wire

// File: doc/csr_except_unit.md
# csr_except_unit

Machine-mode CSR file and exception/trap controller for the single-issue RV32 core, instantiated inside the writeback stage. It decodes the retiring instruction for CSR accesses, supplies the old CSR value for the rd write, and updates CSRs at the clock edge. On a reported exception or an `MRET`, it redirects fetch via `flush`/`flush_addr`.

## Interface
Parameters:
- `XLEN`, default 32, data, address and instruction width.
- `EXW`, default 4, exception cause code width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high.
- `PC`  in  XLEN  PC of the retiring instruction.
- `instr`  in  XLEN  raw retiring instruction.
- `exception_valid`  in  1  the retiring instruction raised an exception.
- `exception`  in  EXW  cause code (0 misaligned fetch, 2 illegal, 3 ebreak, 4/6 misaligned ld/st, 11 ecall).
- `wr_data`  in  XLEN  rs1 value carried down the pipe.
- `flush`  out  1  redirect the pipeline.
- `flush_addr`  out  XLEN  redirect target.
- `rd_addr`  out  5  destination register `instr[11:7]`.
- `rd_data`  out  XLEN  old value of the addressed CSR.

## Operation
- An instruction is a CSR op when `instr[6:0]=1110011` and `funct3=instr[14:12]` is not 000 or 100. The CSR address is `instr[31:20]`. The source is `wr_data` for funct3 001/010/011, or zimm = zero-extended `instr[19:15]` for 101/110/111.
- New value by op:
  - RW/RWI: new = src.
  - RS/RSI: new = old | src.
  - RC/RCI: new = old & ~src.
- RS/RC and their immediate forms do not write when the `instr[19:15]` field is 0.
- Writes to read-only CSRs (`addr[11:10]=11`) and to unimplemented addresses are ignored. Unimplemented CSRs read as 0.
- Implemented CSRs:
  - mstatus 0x300: only MIE bit 3 and MPIE bit 7 are writable; MPP bits 12:11 read as 11.
  - misa 0x301: reads 0x40000100, read-only.
  - mie 0x304: read/write.
  - mtvec 0x305: direct mode; bits 1:0 read as 0.
  - mscratch 0x340: read/write.
  - mepc 0x341: bits 1:0 forced to 0.
  - mcause 0x342: read/write.
  - mtval 0x343: read/write.
  - mip 0x344: reads 0.
  - mcycle/mcycleh 0xB00/0xB80 and cycle/cycleh 0xC00/0xC80: 64-bit counter, +1 every cycle, writable via 0xB00/0xB80.
  - mvendorid, marchid, mimpid, mhartid 0xF11–0xF14: read 0.
- Exception (`exception_valid=1`):
  - `flush=1`, `flush_addr = mtvec & ~3`.
  - At the edge: mepc←PC, mcause←zero-extended `exception`, mtval←`instr` for cause 2 and 0 otherwise, MPIE←MIE, MIE←0.
  - Any CSR write from the same instruction is suppressed.
- MRET (`instr=0x30200073`, no exception):
  - `flush=1`, `flush_addr = mepc`.
  - At the edge: MIE←MPIE, MPIE←1.
- Otherwise `flush=0` and `flush_addr=0`.
- `rd_addr` and `rd_data` are always driven. The caller only consumes them for SYSTEM ops without an exception.
- There is no valid input. A stalled instruction held at the port re-applies its write, which is idempotent for all ops.

## Timing
- `rd_data`, `rd_addr`, `flush` and `flush_addr` are combinational from the inputs and current CSR state: zero latency.
- All CSR updates take effect on the next rising `clk`. A read in cycle N+1 sees the write made in cycle N.
- Reset values: all CSRs 0 (mstatus reads 0x00001800), counter 0. While `reset=1`, `flush=0` and no CSR updates occur.
- Priority: reset > exception > MRET > CSR write.
- When a CSR write targets mcycle in the same cycle as the increment, the written value wins (no +1).
- Counter wraps at 2^64−1 → 0.

## Structure
- Shared package holds:
  - CSR address constants.
  - The SYSTEM opcode and funct3 encodings.
  - The MRET encoding.
  - Exception cause codes.
  - The misa constant.
- Natural sub-module `csr_regfile`: storage, read mux and write logic. The top level holds decode, trap/MRET sequencing and the flush outputs.

## Test plan
- Reset, then CSRRW x5, mscratch with `wr_data=0xDEADBEEF` → `rd_data=0` and `rd_addr=5`. A following CSRRS x0 reads 0xDEADBEEF.
- mtvec←0x00000103. Exception cause 11 at PC 0x80 → `flush=1`, `flush_addr=0x100`. Afterwards mepc=0x80, mcause=11, mtval=0, MIE=0.
- MIE=1, then illegal-instruction exception with `instr=0xFFFFFFFF` → mtval=0xFFFFFFFF, MPIE=1, MIE=0. MRET → `flush_addr=mepc`, MIE=1.
- CSRRC mscratch with rs1 field 0 → no change. CSRRCI with zimm 0x3 on 0xF → 0xC.
- Write mhartid or misa → values unchanged (0 / 0x40000100). Read 0x7C0 → 0.
- Read mcycle across 3 idle cycles after reset → increments by 1 per cycle. CSR op together with `exception_valid=1` → no CSR write.
